uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side UART peripheral on the m68k bus: deserialises 8N1 frames from the `rx` pin and buffers the bytes in a FIFO. It exposes a data register and a status register to the CPU through the same `addr`/`rw`/`uds`/`lds` strobe interface as the existing `uart` block. It is the target-side counterpart of the host serial stream and sits beside `uart` in `top`, with `rx` driven from the board pin.

## Interface
- `DIVISOR`, 868: clock cycles per bit (100 MHz / 115200).
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 bytes.
- `clk` in 1: system clock, single clock domain.
- `reset_n` in 1: reset, asynchronous, active-low.
- `rx` in 1: serial input, idle high, asynchronous to `clk`.
- `addr` in 1: 0 = DATA register, 1 = STATUS register.
- `rw` in 1: 1 = read, 0 = write.
- `uds` in 1: upper byte strobe, active-high, held for multiple cycles.
- `lds` in 1: lower byte strobe, active-high, held for multiple cycles.
- `data_write` in 16: write data.
- `data_read` out 16: read data, combinational from `addr`.
- `rx_avail` out 1: FIFO not empty.

## Operation
- **Input sync:** `rx` goes through a 2-flop synchroniser; both flops reset to 1.
- **Receiver FSM**, states IDLE, START, DATA, STOP:
  - IDLE: a falling edge of the synchronised `rx` loads the bit counter with DIVISOR/2 and moves to START.
  - START: at counter expiry, if `rx`=0 go to DATA with the counter reloaded to DIVISOR; otherwise it was a glitch, return to IDLE.
  - DATA: sample 8 bits, LSB first, one sample every DIVISOR cycles.
  - STOP: sample once. If 1, push the byte. If 0, discard the byte and set FERR. Return to IDLE in both cases.
- **FIFO full:** a push into a full FIFO drops the new byte and sets OVR. Existing contents are untouched.
- **Access event:** a rising edge of `(uds|lds)`, edge-detected against a registered copy, counts as one access. A held strobe never repeats the action.
- **DATA read** (`addr`=0, `rw`=1): `data_read` = {head, head}, so the byte appears on both lanes. The access event pops one entry. A pop on an empty FIFO is ignored and returns 0x0000.
- **STATUS read** (`addr`=1, `rw`=1): `data_read` fields:
  - [0] not empty
  - [1] full
  - [2] OVR (sticky)
  - [3] FERR (sticky)
  - [8:4] count
  - all other bits 0
- **STATUS write** (`addr`=1, `rw`=0, `lds` set): write-1-to-clear. `data_write[2]` clears OVR; `data_write[3]` clears FERR.
- **DATA write:** ignored.
- **Simultaneous push and pop:** both occur in the same cycle and count is unchanged. If the FIFO is full, the pop frees space, so the push succeeds and OVR is not set. If the FIFO is empty, the pop is ignored and the push succeeds.
- **Pointers:** DEPTH_LOG2+1 bits wide. Empty when the pointers are equal. Full when the MSBs differ and the low bits are equal. Wrap-around is natural.

## Timing
- **Reset values:** FSM in IDLE; pointers 0; OVR/FERR 0; `rx_avail` 0; `data_read` 0x0000 (addr=0, FIFO empty).
- **Push latency:** the push happens in the clock cycle where the synchronised falling edge is detected + DIVISOR/2 + 9·DIVISOR. That is about 2 cycles plus that interval after the pin edge.
- **`rx_avail`:** rises the cycle after the push. Falls the cycle after the popping edge, if that pop emptied the FIFO.
- **Status/data after pop:** the head and count update one cycle after the strobe edge. A read sampled while the strobe is still held sees the next entry.
- **Mid-operation reset:** asserting `reset_n` mid-frame or mid-access aborts everything immediately. A partial frame is never pushed.
- **Back-to-back frames:** a new start bit is accepted in the cycle after STOP finishes. No idle gap is required beyond the stop bit.

## Structure
- **`uart_pkg`:** register addresses (`REG_DATA`, `REG_STATUS`), status bit indices, and the rx FSM state enum. The existing `uart` adopts the same package.
- **`sync_fifo` sub-module:** parameterised width/DEPTH_LOG2; provides push, pop, head, count, full and empty. It is reusable for a future TX FIFO.
- **`uart_rx_fifo` itself:** synchroniser, baud counter, FSM, strobe edge detect, register mux.

## Test plan
All scenarios run with DIVISOR=8 in simulation.
- **Single byte:** send 0x41 with correct framing -> `rx_avail` rises; DATA read returns 0x4141; `rx_avail` falls after the strobe edge; STATUS = 0x0000.
- **Fill and overflow:** send 17 bytes 0x00..0x10 with no reads -> STATUS reads full=1, count=16, OVR=1. Sixteen reads return 0x00..0x0F in order; the 17th read returns 0x0000 and count stays 0.
- **Framing error:** send 0x55 with the stop bit held low -> no push, FERR=1. Writing STATUS 0x0008 clears FERR; OVR is unaffected.
- **Glitch rejection:** pulse `rx` low for 2 cycles -> FSM returns to IDLE; FIFO stays empty, no FERR.
- **Held strobe and same-cycle events:** hold `uds` for 20 cycles on a DATA read -> exactly one pop. Align a pop with a push while count=16 -> count stays 16, no OVR.
- **Reset during frame:** assert `reset_n` low during data bit 4 -> all outputs return to their reset values; the next full frame 0xA5 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: register map, STATUS bit layout
// and the receiver state encoding.
package uart_pkg;

    // Register select on the single address line
    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    // STATUS register bit positions
    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVR       = 2;
    localparam int STAT_FERR      = 3;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_COUNT_W   = 5;

    // Receiver frame states
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// CPU-side strobe bus shared by the UART peripherals. The CPU is the master;
// the peripheral answers through data_read.
interface uart_rx_fifo_if;
    logic        addr;
    logic        rw;
    logic        uds;
    logic        lds;
    logic [15:0] data_write;
    logic [15:0] data_read;

    modport master (
        output addr, rw, uds, lds, data_write,
        input  data_read
    );

    modport slave (
        input  addr, rw, uds, lds, data_write,
        output data_read
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. A pop on empty is ignored; a push
// on full is dropped unless a pop in the same cycle makes room.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_head,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic                w_do_push;
    logic                w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                     (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_head  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

    // A pop in the same cycle frees the slot the push needs.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Pointer advance; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: non-blocking (<=) for every flop so all registers see pre-edge values.
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; the pointers alone define what is valid.
        if (w_do_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a byte FIFO, exposed as DATA/STATUS registers on the
// CPU strobe bus. DATA reads pop; STATUS holds sticky overrun/framing flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DIVISOR    = 868,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           rx,
    uart_rx_fifo_if.slave  bus,
    output logic           rx_avail
);

    localparam int CNT_W = $clog2(DIVISOR + 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(DIVISOR / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(DIVISOR);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    // Input synchroniser and edge detect
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;
    logic w_rx_fall;

    // Receiver
    rx_state_e  r_state;
    rx_state_e  w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0] r_bit_idx;
    logic [2:0] w_bit_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic       w_tick;
    logic       w_push;
    logic       w_ferr_set;

    // Bus side
    logic r_strobe_q;
    logic w_access;
    logic w_pop;
    logic w_clr;
    logic r_ovr;
    logic r_ferr;
    logic w_ovr_set;
    logic [15:0] w_status;
    logic        w_unused_wdata;

    // FIFO view
    logic [7:0]          w_head;
    logic [DEPTH_LOG2:0] w_count;
    logic                w_full;
    logic                w_empty;

    // Two-flop synchroniser plus one stage for falling-edge detection; idle high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;
    assign w_tick    = (r_cnt == CNT_ONE);

    // Receiver state and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // Receiver next state: mid-bit sampling driven by the baud down-counter.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    w_state_nxt = RX_START;
                    w_cnt_nxt   = HALF_BIT;
                end
            end
            RX_START: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else if (!r_rx_sync) begin
                    w_state_nxt = RX_DATA;
                    w_cnt_nxt   = FULL_BIT;
                    w_bit_nxt   = '0;
                end else begin
                    // Line went high again before mid start bit: a glitch.
                    w_state_nxt = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else begin
                    w_shift_nxt = {r_rx_sync, r_shift[7:1]};
                    w_cnt_nxt   = FULL_BIT;
                    if (r_bit_idx == 3'd7) w_state_nxt = RX_STOP;
                    else                   w_bit_nxt   = r_bit_idx + 3'd1;
                end
            end
            RX_STOP: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else begin
                    w_push      = r_rx_sync;
                    w_ferr_set  = ~r_rx_sync;
                    w_state_nxt = RX_IDLE;
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Registered strobe copy so a held strobe acts only once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_strobe_q <= 1'b0;
        else          r_strobe_q <= bus.uds | bus.lds;
    end

    assign w_access  = (bus.uds | bus.lds) & ~r_strobe_q;
    assign w_pop     = w_access & bus.rw & (bus.addr == REG_DATA);
    assign w_clr     = w_access & ~bus.rw & (bus.addr == REG_STATUS) & bus.lds;
    // A full FIFO only overflows when no pop is freeing a slot this cycle.
    assign w_ovr_set = w_push & w_full & ~w_pop;

    assign w_unused_wdata = ^{bus.data_write[15:4], bus.data_write[1:0]};

    // Sticky flags; a new event wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_ovr_set)                              r_ovr  <= 1'b1;
            else if (w_clr && bus.data_write[STAT_OVR]) r_ovr  <= 1'b0;
            if (w_ferr_set)                              r_ferr <= 1'b1;
            else if (w_clr && bus.data_write[STAT_FERR]) r_ferr <= 1'b0;
        end
    end

    // Register read mux; DATA shows the head byte on both lanes.
    always_comb begin
        w_status = '0;
        w_status[STAT_NOT_EMPTY] = ~w_empty;
        w_status[STAT_FULL]      = w_full;
        w_status[STAT_OVR]       = r_ovr;
        w_status[STAT_FERR]      = r_ferr;
        w_status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(w_count);
        bus.data_read = '0;
        if (bus.addr == REG_STATUS) bus.data_read = w_status;
        else if (!w_empty)          bus.data_read = {w_head, w_head};
    end

    assign rx_avail = ~w_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a queue-based model.
module tb_uart_rx_fifo;

    localparam int BIT   = 8;
    localparam int DL2   = 4;
    localparam int DEPTH = 16;
    // Pin driven just after edge n: synchroniser output low after edge n+2,
    // detected in the following cycle, then D/2 + 9*D cycles to the stop
    // sample, which takes effect on the next edge.
    localparam int PUSH_LAT = 3 + BIT / 2 + 9 * BIT;

    typedef struct {
        int         due;
        logic [7:0] data;
        bit         ok;
    } frame_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rx = 1'b1;
    logic rx_avail;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(
        .DIVISOR    (BIT),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx       (rx),
        .bus      (bus),
        .rx_avail (rx_avail)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model state
    logic [7:0] mq[$];
    bit         m_ovr;
    bit         m_ferr;
    bit         m_prev_strobe;
    int         m_edge;
    bit         m_access;
    frame_t     pending[$];
    bit         tx_done;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_read();
        int st;
        if (bus.addr == 1'b0) begin
            if (mq.size() == 0) return 16'h0000;
            return {mq[0], mq[0]};
        end
        st = mq.size() * 16 + (m_ferr ? 8 : 0) + (m_ovr ? 4 : 0) +
             ((mq.size() == DEPTH) ? 2 : 0) + ((mq.size() != 0) ? 1 : 0);
        return st[15:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: per clock edge, pop then clear then frame result.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            pending.delete();
            m_ovr = 1'b0;
            m_ferr = 1'b0;
            m_prev_strobe = 1'b0;
        end else begin
            m_edge = cyc + 1;
            m_access = (bus.uds | bus.lds) && !m_prev_strobe;
            m_prev_strobe = bus.uds | bus.lds;
            if (m_access && bus.rw && bus.addr == 1'b0 && mq.size() > 0)
                void'(mq.pop_front());
            if (m_access && !bus.rw && bus.addr == 1'b1 && bus.lds) begin
                if (bus.data_write[2]) m_ovr = 1'b0;
                if (bus.data_write[3]) m_ferr = 1'b0;
            end
            while (pending.size() > 0 && pending[0].due <= m_edge) begin
                if (!pending[0].ok)          m_ferr = 1'b1;
                else if (mq.size() < DEPTH)  mq.push_back(pending[0].data);
                else                         m_ovr = 1'b1;
                void'(pending.pop_front());
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            check("rx_avail", {15'd0, rx_avail}, {15'd0, mq.size() != 0});
            check("data_read", bus.data_read, model_read());
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit ok);
        frame_t f;
        step(1);
        rx = 1'b0;
        f.due = cyc + PUSH_LAT;
        f.data = b;
        f.ok = ok;
        pending.push_back(f);
        for (int i = 0; i < 8; i++) begin
            step(BIT);
            rx = b[i];
        end
        step(BIT);
        rx = ok;
        step(BIT - 1);
        if (!ok) begin
            step(1);
            rx = 1'b1;
        end
    endtask

    task automatic cpu(input logic a, input logic rw, input logic u, input logic l,
                       input logic [15:0] wd, input int hold);
        step(1);
        bus.addr = a;
        bus.rw = rw;
        bus.data_write = wd;
        bus.uds = u;
        bus.lds = l;
        step(hold);
        bus.uds = 1'b0;
        bus.lds = 1'b0;
    endtask

    task automatic rd_data(input int hold);
        cpu(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, hold);
    endtask

    task automatic wr_status(input logic [15:0] v);
        cpu(1'b1, 1'b0, 1'b0, 1'b1, v, 1);
    endtask

    task automatic peek(input logic a);
        step(1);
        bus.addr = a;
        bus.rw = 1'b1;
        @(negedge clk);
    endtask

    // Issue a DATA read whose access cycle coincides with the push of the
    // frame most recently queued.
    task automatic pop_at_push();
        int due;
        step(2);
        due = pending[pending.size() - 1].due;
        while (cyc < due - 1) step(1);
        bus.addr = 1'b0;
        bus.rw = 1'b1;
        bus.uds = 1'b1;
        step(2);
        bus.uds = 1'b0;
    endtask

    initial begin
        logic [7:0] partial;
        bus.addr = 1'b0;
        bus.rw = 1'b1;
        bus.uds = 1'b0;
        bus.lds = 1'b0;
        bus.data_write = 16'h0000;
        tx_done = 1'b0;

        // Reset state
        step(3);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_avail", {15'd0, rx_avail}, 16'h0000);
        check("reset_data", bus.data_read, 16'h0000);
        peek(1'b1);
        check("reset_status", bus.data_read, 16'h0000);

        // Single byte
        send_frame(8'h41, 1'b1);
        step(2);
        peek(1'b0);
        check("single_avail", {15'd0, rx_avail}, 16'h0001);
        check("single_data", bus.data_read, 16'h4141);
        rd_data(3);
        @(negedge clk);
        check("single_avail_fall", {15'd0, rx_avail}, 16'h0000);
        peek(1'b1);
        check("single_status", bus.data_read, 16'h0000);

        // Fill and overflow, back-to-back frames
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
        step(2);
        peek(1'b1);
        check("fill_status", bus.data_read, 16'h0107);
        for (int i = 0; i < 16; i++) begin
            peek(1'b0);
            check("fill_order", bus.data_read, {8'(i), 8'(i)});
            rd_data(1);
        end
        peek(1'b0);
        check("empty_read", bus.data_read, 16'h0000);
        rd_data(1);
        peek(1'b1);
        check("empty_pop_status", bus.data_read, 16'h0004);

        // Framing error and W1C
        send_frame(8'h55, 1'b0);
        step(2);
        peek(1'b1);
        check("ferr_status", bus.data_read, 16'h000C);
        wr_status(16'h0008);
        peek(1'b1);
        check("ferr_clear", bus.data_read, 16'h0004);
        wr_status(16'h0004);
        peek(1'b1);
        check("ovr_clear", bus.data_read, 16'h0000);

        // Glitch rejection
        step(1);
        rx = 1'b0;
        step(2);
        rx = 1'b1;
        step(20);
        peek(1'b1);
        check("glitch_status", bus.data_read, 16'h0000);

        // Held strobe pops once
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        step(2);
        cpu(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 20);
        peek(1'b1);
        check("held_status", bus.data_read, 16'h0011);
        peek(1'b0);
        check("held_head", bus.data_read, 16'h2222);
        rd_data(1);

        // Push and pop in the same cycle while full
        for (int i = 0; i < 16; i++) send_frame(8'h30 + 8'(i), 1'b1);
        step(2);
        peek(1'b1);
        check("full_status", bus.data_read, 16'h0103);
        fork
            send_frame(8'h80, 1'b1);
            pop_at_push();
        join
        step(2);
        peek(1'b1);
        check("same_cycle_status", bus.data_read, 16'h0103);
        peek(1'b0);
        check("same_cycle_head", bus.data_read, 16'h3131);
        repeat (DEPTH) rd_data(1);
        peek(1'b1);
        check("drained_status", bus.data_read, 16'h0000);

        // Reset during a frame
        send_frame(8'h5A, 1'b1);
        send_frame(8'h00, 1'b0);
        step(2);
        peek(1'b1);
        check("pre_reset_status", bus.data_read, 16'h0019);
        partial = 8'hC3;
        bus.addr = 1'b0;
        step(1);
        rx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(BIT);
            rx = partial[i];
        end
        step(4);
        reset_n = 1'b0;
        rx = 1'b1;
        #1;
        check("midreset_avail", {15'd0, rx_avail}, 16'h0000);
        check("midreset_data", bus.data_read, 16'h0000);
        step(3);
        reset_n = 1'b1;
        peek(1'b1);
        check("post_reset_status", bus.data_read, 16'h0000);
        send_frame(8'hA5, 1'b1);
        step(2);
        peek(1'b0);
        check("post_reset_data", bus.data_read, 16'hA5A5);
        rd_data(1);

        // Randomized traffic against the model
        fork
            begin
                for (int k = 0; k < 25; k++) begin
                    int gap;
                    send_frame(8'($urandom), $urandom_range(0, 7) != 0);
                    gap = $urandom_range(0, 15);
                    if (gap > 0) step(gap);
                end
                tx_done = 1'b1;
            end
            begin
                while (!tx_done) begin
                    logic u;
                    logic l;
                    int gap;
                    u = 1'($urandom_range(0, 1));
                    l = 1'($urandom_range(0, 1));
                    if (!u && !l) l = 1'b1;
                    cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), u, l,
                        16'($urandom), $urandom_range(1, 6));
                    gap = $urandom_range(0, 40);
                    if (gap > 0) step(gap);
                end
            end
        join
        repeat (DEPTH + 1) rd_data(1);
        step(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
